// File: rtl/seq_ctrl.sv
// seq_ctrl - multi-cycle control sequencer for the 8-bit-instruction core.
// Owns the instruction PC and steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB. It drives the ALU, register-file and data-memory
// enables, and it resolves jumps, branches, HALT and data-memory timeouts.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin execution from PC_RESET (honoured in IDLE/HALT only)
//   opcode       decoded opcode of the instruction at pc
//   format       decoded format (C/I/M/X); control flow depends on opcode only
//   alu_eq       ALU operands equal (valid in EXEC)
//   alu_lt       ALU operand1 < operand2, unsigned (valid in EXEC)
//   jump_target  register-sourced target for JMP / taken branches (EXEC)
//   mem_ack      data memory completes the access (sampled in MEM only)
//   pc           instruction address to the ROM
//   alu_en       ALU evaluate strobe (EXEC)
//   mem_req      data memory request (MEM)
//   mem_we       1 = store, 0 = load; valid while mem_req is high
//   reg_we       register-file write strobe (WB)
//   busy         high in every state except IDLE and HALT
//   halted       high in HALT
//   err          sticky memory-timeout flag
//   retired      one-cycle pulse when an instruction completes
//   state        encoded current state, for debug
module seq_ctrl #(
  parameter logic [15:0] PC_RESET    = 16'h0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [1:0]  format,
  input  logic        alu_eq,
  input  logic        alu_lt,
  input  logic [15:0] jump_target,
  input  logic        mem_ack,
  output logic [15:0] pc,
  output logic        alu_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_we,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic        retired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    HALT    = 3'd6,
    ILLEGAL = 3'd7
  } state_t;

  localparam logic [3:0] OP_LB   = 4'b0000;
  localparam logic [3:0] OP_LHB  = 4'b0001;
  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_STR  = 4'b0011;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1110;
  localparam logic [3:0] OP_TBA  = 4'b1111;

  // Value the counter holds during the last MEM cycle allowed without ack.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        taken;

  // Format does not influence sequencing; only the opcode matters here.
  logic unused_format;
  assign unused_format = ^format;

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BNE:  taken = ~alu_eq;
      OP_BEQ:  taken = alu_eq;
      OP_BLT:  taken = alu_lt;
      default: taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = PC_RESET;
          err_d   = 1'b0;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (opcode == OP_HALT) state_d = HALT;
        else                   state_d = EXEC;
      end
      EXEC: begin
        case (opcode)
          OP_LB, OP_LHB, OP_STR: begin
            state_d = MEM;
            cnt_d   = '0;
          end
          OP_JMP: begin
            state_d = FETCH;
            pc_d    = jump_target;
          end
          OP_BNE, OP_BEQ, OP_BLT: begin
            state_d = FETCH;
            pc_d    = taken ? jump_target : pc_q + 16'd1;
          end
          OP_TBA: begin
            state_d = FETCH;
            pc_d    = pc_q + 16'd1;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        if (mem_ack) begin
          if (opcode == OP_STR) begin
            state_d = FETCH;
            pc_d    = pc_q + 16'd1;
          end else begin
            state_d = WB;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WB: begin
        state_d = FETCH;
        pc_d    = pc_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: strobes depend on the registered state only
  always_comb begin
    alu_en  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    reg_we  = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    retired = 1'b0;
    case (state_q)
      FETCH: busy = 1'b1;
      DECODE: begin
        busy    = 1'b1;
        retired = (opcode == OP_HALT);
      end
      EXEC: begin
        busy    = 1'b1;
        alu_en  = 1'b1;
        retired = (opcode == OP_JMP) || (opcode == OP_BNE) ||
                  (opcode == OP_BEQ) || (opcode == OP_BLT) ||
                  (opcode == OP_TBA);
      end
      MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STR);
        retired = mem_ack && (opcode == OP_STR);
      end
      WB: begin
        busy    = 1'b1;
        reg_we  = 1'b1;
        retired = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  assign pc    = pc_q;
  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed testbench for seq_ctrl. A 16-entry ROM indexed by pc[3:0] feeds
// the opcode; expected values are hand-derived cycle by cycle, where cycle 1
// is the FETCH that follows start.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic [1:0]  format;
  logic        alu_eq;
  logic        alu_lt;
  logic [15:0] jump_target;
  logic        mem_ack;
  logic [15:0] pc;
  logic        alu_en, mem_req, mem_we, reg_we, busy, halted, err, retired;
  logic [2:0]  state;

  logic [3:0]  rom_op [16];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] ADD = 4'h4, LB = 4'h0, STR = 4'h3, JMP = 4'h2;
  localparam logic [3:0] BEQ = 4'hB, HLT = 4'hE, TBA = 4'hF;

  seq_ctrl #(.PC_RESET(16'h0000), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .format(format),
    .alu_eq(alu_eq), .alu_lt(alu_lt), .jump_target(jump_target),
    .mem_ack(mem_ack), .pc(pc), .alu_en(alu_en), .mem_req(mem_req),
    .mem_we(mem_we), .reg_we(reg_we), .busy(busy), .halted(halted),
    .err(err), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  always_comb begin
    opcode = rom_op[pc[3:0]];
    format = 2'b00;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    start = 1'b0; mem_ack = 1'b0; alu_eq = 1'b0; alu_lt = 1'b0;
    jump_target = 16'h0000;
    for (int unsigned i = 0; i < 16; i++) rom_op[i] = TBA;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic start_run;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    n_checks++;
    if (state !== 3'd0 || pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d pc=%h, required state=0 pc=0000", state, pc);
    end
    n_checks++;
    if ({alu_en, mem_req, mem_we, reg_we, busy, halted, err, retired} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {alu_en, mem_req, mem_we, reg_we, busy, halted, err, retired});
    end
    tick;
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_hold: state=%0d, required 0", state);
    end
  endtask

  task automatic test_add_add_halt;
    int ret_cnt = 0;
    logic [15:0] exp_pc;
    apply_reset;
    rom_op[0] = ADD; rom_op[1] = ADD; rom_op[2] = HLT;
    start_run;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) tick;
      #1;
      exp_pc = (c <= 4) ? 16'd0 : (c <= 8) ? 16'd1 : 16'd2;
      if (retired === 1'b1) ret_cnt++;
      n_checks++;
      if (pc !== exp_pc || reg_we !== (c == 4 || c == 8) || halted !== (c == 11)) begin
        n_fail++;
        $display("FAIL add_seq cycle %0d: pc=%h reg_we=%b halted=%b, required pc=%h reg_we=%b halted=%b",
                 c, pc, reg_we, halted, exp_pc, (c == 4 || c == 8), (c == 11));
      end
    end
    n_checks++;
    if (ret_cnt != 3) begin
      n_fail++;
      $display("FAIL add_seq_retired: got %0d pulses, required 3", ret_cnt);
    end
  endtask

  task automatic test_branch;
    for (int eq = 1; eq >= 0; eq--) begin
      apply_reset;
      rom_op[0] = JMP; rom_op[5] = BEQ;
      jump_target = 16'h0005;
      start_run;
      for (int c = 1; c <= 7; c++) begin
        if (c > 1) tick;
        if (c == 4) begin
          jump_target = 16'h0040;
          alu_eq = (eq == 1);
        end
        #1;
        n_checks++;
        if (reg_we !== 1'b0 || alu_en !== (c == 3 || c == 6)) begin
          n_fail++;
          $display("FAIL branch_strobes eq=%0d cycle %0d: reg_we=%b alu_en=%b", eq, c, reg_we, alu_en);
        end
        if (c == 4) begin
          n_checks++;
          if (pc !== 16'h0005) begin
            n_fail++;
            $display("FAIL jmp_pc: pc=%h, required 0005", pc);
          end
        end
        if (c == 6) begin
          n_checks++;
          if (retired !== 1'b1 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL branch_retire eq=%0d: retired=%b state=%0d, required 1/3", eq, retired, state);
          end
        end
        if (c == 7) begin
          n_checks++;
          if (pc !== ((eq == 1) ? 16'h0040 : 16'h0006) || state !== 3'd1) begin
            n_fail++;
            $display("FAIL branch_pc eq=%0d: pc=%h state=%0d, required pc=%h state=1",
                     eq, pc, state, (eq == 1) ? 16'h0040 : 16'h0006);
          end
        end
      end
    end
  endtask

  task automatic test_load_store;
    logic [15:0] exp_pc;
    apply_reset;
    rom_op[0] = LB; rom_op[1] = STR; rom_op[2] = HLT;
    start_run;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) tick;
      mem_ack = (c == 7 || c == 12);
      #1;
      exp_pc = (c <= 8) ? 16'd0 : (c <= 12) ? 16'd1 : 16'd2;
      n_checks++;
      if (mem_req !== ((c >= 4 && c <= 7) || c == 12) || mem_we !== (c == 12) ||
          reg_we !== (c == 8) || retired !== (c == 8 || c == 12) || pc !== exp_pc) begin
        n_fail++;
        $display("FAIL ldst cycle %0d: req=%b we=%b reg_we=%b retired=%b pc=%h, required %b %b %b %b %h",
                 c, mem_req, mem_we, reg_we, retired, pc,
                 ((c >= 4 && c <= 7) || c == 12), (c == 12), (c == 8), (c == 8 || c == 12), exp_pc);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout;
    apply_reset;
    rom_op[0] = JMP; rom_op[3] = LB;
    jump_target = 16'h0003;
    start_run;
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) tick;
      #1;
      n_checks++;
      if (mem_req !== (c >= 7 && c <= 21) || reg_we !== 1'b0 ||
          err !== (c == 22) || halted !== (c == 22)) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: req=%b reg_we=%b err=%b halted=%b", c, mem_req, reg_we, err, halted);
      end
    end
    n_checks++;
    if (state !== 3'd6 || pc !== 16'h0003) begin
      n_fail++;
      $display("FAIL timeout_halt: state=%0d pc=%h, required 6/0003", state, pc);
    end
    tick;
    n_checks++;
    if (err !== 1'b1 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b halted=%b, required 1/1", err, halted);
    end
    start_run;
    #1;
    n_checks++;
    if (err !== 1'b0 || pc !== 16'h0000 || busy !== 1'b1 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL restart: err=%b pc=%h busy=%b state=%0d, required 0/0000/1/1", err, pc, busy, state);
    end
  endtask

  task automatic test_wrap_and_reset;
    apply_reset;
    rom_op[0] = JMP; rom_op[15] = ADD;
    jump_target = 16'hFFFF;
    start_run;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick;
      #1;
      if (c == 4) begin
        n_checks++;
        if (pc !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL jmp_ffff: pc=%h, required ffff", pc);
        end
      end
      n_checks++;
      if (reg_we !== (c == 7)) begin
        n_fail++;
        $display("FAIL wrap_reg_we cycle %0d: got %b, required %b", c, reg_we, (c == 7));
      end
      if (c == 8) begin
        n_checks++;
        if (pc !== 16'h0000 || state !== 3'd1) begin
          n_fail++;
          $display("FAIL pc_wrap: pc=%h state=%0d, required 0000/1", pc, state);
        end
      end
    end
    apply_reset;
    rom_op[0] = JMP; rom_op[5] = LB;
    jump_target = 16'h0005;
    start_run;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick;
      #1;
    end
    n_checks++;
    if (mem_req !== 1'b1 || pc !== 16'h0005) begin
      n_fail++;
      $display("FAIL pre_reset_mem: req=%b pc=%h, required 1/0005", mem_req, pc);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || pc !== 16'h0000 ||
        {alu_en, mem_req, mem_we, reg_we, busy, halted, err, retired} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d pc=%h outs=%b, required 0/0000/00000000",
               state, pc, {alu_en, mem_req, mem_we, reg_we, busy, halted, err, retired});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start_while_busy;
    apply_reset;
    rom_op[0] = TBA; rom_op[1] = HLT;
    start_run;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick;
      start = (c == 3);
      #1;
      if (c == 3) begin
        n_checks++;
        if (retired !== 1'b1 || alu_en !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL tba_exec: retired=%b alu_en=%b busy=%b, required 1/1/1", retired, alu_en, busy);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (pc !== 16'h0001 || state !== 3'd1) begin
          n_fail++;
          $display("FAIL start_ignored: pc=%h state=%0d, required 0001/1", pc, state);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (halted !== 1'b1 || pc !== 16'h0001 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL tba_halt: halted=%b pc=%h busy=%b, required 1/0001/0", halted, pc, busy);
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset;
    test_add_add_halt;
    test_branch;
    test_load_store;
    test_timeout;
    test_wrap_and_reset;
    test_start_while_busy;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
- Multi-cycle control sequencer for the 8-bit-instruction core.
- Owns the 16-bit PC that addresses the instruction ROM, and consumes the decoded opcode/format.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives ALU, register-file and data-memory enables, and resolves jumps, branches and HALT.
- Sits between the instruction ROM/decoder and the datapath.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset and on every start.
MEM_TIMEOUT, 15, maximum cycles in MEM without mem_ack before an error halt (legal range 1..255).

Ports:
clk  in  1  Single clock; all state updates on its rising edge.
rst_n  in  1  Asynchronous active-low reset; release is synchronised externally.
start  in  1  Begins execution from PC_RESET; honoured only in IDLE or HALT.
opcode  in  4  Decoded opcode of the instruction at pc.
format  in  2  Decoded format: 00=C, 01=I, 10=M, 11=X.
alu_eq  in  1  ALU operands equal; valid in EXEC.
alu_lt  in  1  ALU operand1 < operand2, unsigned; valid in EXEC.
jump_target  in  16  Register-sourced target for JMP and taken branches; valid in EXEC.
mem_ack  in  1  Data memory completes the access.
pc  out  16  Instruction address to the ROM.
alu_en  out  1  ALU evaluate strobe.
mem_req  out  1  Data memory request.
mem_we  out  1  1 = store, 0 = load; valid while mem_req is high.
reg_we  out  1  Register-file write strobe.
busy  out  1  High in every state except IDLE and HALT.
halted  out  1  High in HALT.
err  out  1  Sticky memory-timeout flag.
retired  out  1  One-cycle pulse when an instruction completes.
state  out  3  Encoded current state, for debug.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE(0), pc=PC_RESET, timeout counter=0.
  - All strobes, busy, halted, err and retired are 0.
  - Reset mid-instruction abandons the instruction with no write.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is illegal and recovers to IDLE on the next edge.
- IDLE: start=1 -> FETCH with pc=PC_RESET. Otherwise remain in IDLE.
- FETCH -> DECODE unconditionally. The ROM is combinational, so opcode/format are valid from DECODE onward.
- DECODE:
  - opcode HALT (1110) -> HALT; retired pulses and pc is not changed.
  - All other opcodes -> EXEC.
- EXEC: alu_en=1 for exactly this cycle.
  - LB (0000), LHB (0001), STR (0011) -> MEM.
  - JMP (0010): pc<=jump_target, retired, -> FETCH.
  - BNE (1010), BEQ (1011), BLT (1100):
    - Taken conditions: BNE when !alu_eq, BEQ when alu_eq, BLT when alu_lt.
    - Taken: pc<=jump_target. Not taken: pc<=pc+1.
    - retired, -> FETCH.
  - TBA (1111) is a NOP: pc<=pc+1, retired, -> FETCH.
  - All other opcodes -> WB.
- MEM:
  - mem_req=1 for the whole state; mem_we=1 only for STR.
  - mem_ack sampled high:
    - STR: pc<=pc+1, retired, -> FETCH.
    - LB/LHB: -> WB.
  - The timeout counter increments each MEM cycle without ack and clears on entry to MEM.
  - If the counter reaches MEM_TIMEOUT with no ack: err<=1, -> HALT, pc unchanged, no write.
  - mem_ack outside MEM is ignored.
- WB: reg_we=1 for exactly one cycle; pc<=pc+1, retired, -> FETCH.
- HALT:
  - halted=1; pc holds. err persists until reset or start.
  - start=1 -> FETCH with pc=PC_RESET and err cleared.
- pc arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000.
- Latency, FETCH to retire:
  - JMP, branches, TBA: 3 cycles.
  - ALU/I-form/other M-form ops: 4 cycles.
  - STR: 4 + ack wait. LB/LHB: 5 + ack wait.
  - HALT: retires 2 cycles after FETCH.
- Strobes (alu_en, mem_req, reg_we) are registered-state decodes with no glitching; at most one is high in any cycle.
- start while busy is ignored.

Test Plan:
1. Reset then start, ROM sequence ADD, ADD, HALT.
   -> Each ADD shows reg_we in its 4th cycle; pc goes 0,1,2; halted=1 at cycle 11; retired pulses 3 times.
2. BEQ at pc=5 with alu_eq=1 and jump_target=16'h0040.
   -> pc=16'h0040 on the cycle after EXEC; no reg_we.
   Repeat with alu_eq=0 -> pc=6.
3. LB with mem_ack delayed 3 cycles.
   -> mem_req high 4 cycles with mem_we=0, then reg_we for 1 cycle; total 8 cycles FETCH to retire.
   STR with immediate ack -> mem_we=1, no reg_we, retires in 4 cycles.
4. LB with mem_ack held low.
   -> After 15 MEM cycles err=1 and halted=1, no reg_we.
   start -> err=0, pc=PC_RESET, busy=1.
5. JMP to 16'hFFFF followed by ADD.
   -> pc wraps to 16'h0000 after WB.
   Also: assert rst_n low during MEM -> all outputs 0 immediately and state=IDLE.
6. Assert start while in EXEC -> ignored, with no pc change.
   With the ROM sequence TBA, HALT -> pc advances 0 -> 1 in 3 cycles, then halted=1.
